// File: rtl/pkt_tx_pkg.sv
// pkt_tx_pkg: shared state encoding and width helper for the tx framer
package pkt_tx_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    function automatic int empty_width(input int spb);
        return $clog2(spb);
    endfunction
endpackage

// File: rtl/pkt_tx_out_reg.sv
// pkt_tx_out_reg: single-entry holding register for one framed beat
// Ports: load_i captures data/sop/eop/empty and sets valid_o; ready_i drains it;
// simultaneous load and drain keeps valid_o high with the new beat.
module pkt_tx_out_reg #(
    parameter int DW = 64,
    parameter int EW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          ready_i,
    input  logic [DW-1:0] data_i,
    input  logic          sop_i,
    input  logic          eop_i,
    input  logic [EW-1:0] empty_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          sop_o,
    output logic          eop_o,
    output logic [EW-1:0] empty_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q;
    logic          sop_q, eop_q;
    logic [EW-1:0] empty_q;

    always_comb valid_d = load_i ? 1'b1 : (ready_i ? 1'b0 : valid_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                data_q  <= data_i;
                sop_q   <= sop_i;
                eop_q   <= eop_i;
                empty_q <= empty_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/pkt_tx_framer.sv
// pkt_tx_framer: frames a length descriptor plus raw words into a sop/eop/empty stream
// Ports: desc_* descriptor handshake and zero-length error pulse; raw_* payload
// handshake; out_* framed beat stream. Defining PKT_TX_FRAMER_STATS_EN adds
// stat_pkt_cnt (eop beats delivered) and stat_err_cnt (dropped descriptors).
module pkt_tx_framer
    import pkt_tx_pkg::*;
#(
    parameter int SYMBOL_PER_BEATS = 8,
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         desc_valid,
    output logic                                         desc_ready,
    input  logic [LEN_WIDTH-1:0]                         desc_len,
    output logic                                         desc_err,
    input  logic                                         raw_valid,
    output logic                                         raw_ready,
    input  logic [SYMBOL_PER_BEATS*BITS_PER_SYMBOL-1:0]  raw_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [SYMBOL_PER_BEATS*BITS_PER_SYMBOL-1:0]  out_data,
    output logic                                         out_sop,
    output logic                                         out_eop,
    output logic [empty_width(SYMBOL_PER_BEATS)-1:0]     out_empty
`ifdef PKT_TX_FRAMER_STATS_EN
    ,
    output logic [31:0]                                  stat_pkt_cnt,
    output logic [31:0]                                  stat_err_cnt
`endif
);
    localparam int DW = SYMBOL_PER_BEATS * BITS_PER_SYMBOL;
    localparam int EW = empty_width(SYMBOL_PER_BEATS);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] beats_q, beats_d;
    logic [EW-1:0]        tail_q, tail_d;
    logic                 first_q, first_d;
    logic                 err_q, err_d;
    logic                 desc_fire, raw_fire, last;
    logic [EW-1:0]        load_empty;

    assign desc_ready = rst_n && state_q == IDLE;
    assign raw_ready  = rst_n && state_q == SEND && (!out_valid || out_ready);
    assign desc_fire  = desc_valid && desc_ready;
    assign raw_fire   = raw_valid && raw_ready;
    assign last       = beats_q == LEN_WIDTH'(1);
    // (SPB - tail) % SPB is just the two's complement of tail at EW bits
    assign load_empty = last ? -tail_q : '0;
    assign desc_err   = err_q;

    // ceil(len/SPB) as floor plus a carry for a partial tail: cannot overflow LEN_WIDTH
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        tail_d  = tail_q;
        first_d = first_q;
        err_d   = desc_fire && desc_len == '0;
        if (desc_fire && desc_len != '0) begin
            state_d = SEND;
            beats_d = (desc_len >> EW) + LEN_WIDTH'(|desc_len[EW-1:0]);
            tail_d  = desc_len[EW-1:0];
            first_d = 1'b1;
        end
        if (raw_fire) begin
            state_d = last ? IDLE : SEND;
            beats_d = beats_q - 1'b1;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beats_q <= '0;
            tail_q  <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            tail_q  <= tail_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    pkt_tx_out_reg #(.DW(DW), .EW(EW)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (raw_fire),
        .ready_i (out_ready),
        .data_i  (raw_data),
        .sop_i   (first_q),
        .eop_i   (last),
        .empty_i (load_empty),
        .valid_o (out_valid),
        .data_o  (out_data),
        .sop_o   (out_sop),
        .eop_o   (out_eop),
        .empty_o (out_empty)
    );

`ifdef PKT_TX_FRAMER_STATS_EN
    logic [31:0] pkt_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_q + 32'(out_valid && out_ready && out_eop);
            err_cnt_q <= err_cnt_q + 32'(err_q);
        end
    end

    assign stat_pkt_cnt = pkt_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_pkt_tx_framer.sv
// tb_pkt_tx_framer: queue-model bench for pkt_tx_framer with directed and random traffic
module tb_pkt_tx_framer;
    localparam int SPB = 8;
    localparam int BPS = 8;
    localparam int LW  = 16;
    localparam int DW  = SPB * BPS;
    localparam int EW  = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          desc_valid, desc_ready, desc_err;
    logic [LW-1:0] desc_len;
    logic          raw_valid, raw_ready;
    logic [DW-1:0] raw_data;
    logic          out_valid, out_ready, out_sop, out_eop;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_empty;
`ifdef PKT_TX_FRAMER_STATS_EN
    logic [31:0]   stat_pkt_cnt, stat_err_cnt;
`endif

    always #5 clk = ~clk;

    pkt_tx_framer #(.SYMBOL_PER_BEATS(SPB), .BITS_PER_SYMBOL(BPS), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_len   (desc_len),
        .desc_err   (desc_err),
        .raw_valid  (raw_valid),
        .raw_ready  (raw_ready),
        .raw_data   (raw_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_empty  (out_empty)
`ifdef PKT_TX_FRAMER_STATS_EN
        ,
        .stat_pkt_cnt (stat_pkt_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    beat_t         exp_q[$];
    beat_t         seen[$];
    int            seen_cyc[$];
    logic [DW-1:0] raw_q[$];
    logic [LW-1:0] desc_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            err_seen = 0;
    bit            mon_en = 0;
    bit            drv_en = 0;
    int            raw_pct = 100;
    int            rdy_pct = 100;
    int            rdy_low = 0;
    bit            err_pend = 0;
    bit            hold_prev = 0;
    bit            rawf_prev = 0;
    beat_t         prev_b;
    logic [DW-1:0] rawf_word;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected beats come straight from the framing rules: ceil(len/SPB) beats,
    // sop on the first, eop on the last, empty = (SPB - len%SPB) % SPB on eop.
    task automatic add_pkt(input int len, input logic [DW-1:0] base, input bit rnd);
        int    n;
        beat_t b;
        logic [DW-1:0] w;
        desc_q.push_back(LW'(len));
        n = (len + SPB - 1) / SPB;
        for (int i = 0; i < n; i++) begin
            w = rnd ? {$urandom, $urandom} : base + DW'(i);
            raw_q.push_back(w);
            b.data  = w;
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            b.empty = (i == n - 1) ? EW'((SPB - len % SPB) % SPB) : '0;
            exp_q.push_back(b);
        end
    endtask

    task automatic chk_seen(input string name, input int idx, input logic [DW-1:0] d,
                            input bit s, input bit e, input int emp);
        beat_t b;
        if (idx >= seen.size()) begin
            total++;
            bad++;
            $display("FAIL %s: beat %0d missing, only %0d seen", name, idx, seen.size());
        end else begin
            b = seen[idx];
            chk({name, "_data"}, 96'(b.data), 96'(d));
            chk({name, "_sop"}, 96'(b.sop), 96'(s));
            chk({name, "_eop"}, 96'(b.eop), 96'(e));
            chk({name, "_empty"}, 96'(b.empty), 96'(emp));
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((desc_q.size() != 0 || raw_q.size() != 0 || exp_q.size() != 0 || out_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL %s: drain timeout, exp left %0d raw left %0d", name, exp_q.size(), raw_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_seen(input string name, input int n, input int budget);
        int k = 0;
        while (seen.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL %s: timeout waiting for beat %0d, got %0d", name, n, seen.size());
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (drv_en) begin
            desc_valid = desc_q.size() != 0;
            desc_len   = desc_q.size() != 0 ? desc_q[0] : '0;
            raw_valid  = raw_q.size() != 0 && $urandom_range(99) < raw_pct;
            raw_data   = raw_q.size() != 0 ? raw_q[0] : '0;
            out_ready  = rdy_low > 0 ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (rdy_low > 0) rdy_low--;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("desc_err", 96'(desc_err), 96'(err_pend));
            if (desc_err) err_seen++;
            if (hold_prev) begin
                chk("hold_valid", 96'(out_valid), 96'(1));
                chk("hold_beat", 96'({out_data, out_sop, out_eop, out_empty}), 96'(prev_b));
            end
            if (rawf_prev) begin
                chk("latency_valid", 96'(out_valid), 96'(1));
                chk("latency_data", 96'(out_data), 96'(rawf_word));
            end
            if (out_valid && !out_eop) chk("empty_noneop", 96'(out_empty), 96'(0));
            if (out_valid && !out_ready) chk("raw_ready_blocked", 96'(raw_ready), 96'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat: unexpected beat %0h", out_data);
                end else begin
                    chk("beat", 96'({out_data, out_sop, out_eop, out_empty}), 96'(exp_q.pop_front()));
                end
                seen.push_back({out_data, out_sop, out_eop, out_empty});
                seen_cyc.push_back(cyc);
            end
            err_pend = desc_valid && desc_ready && desc_len == '0;
            if (desc_valid && desc_ready && desc_q.size() != 0) void'(desc_q.pop_front());
            rawf_prev = raw_valid && raw_ready;
            rawf_word = raw_data;
            if (rawf_prev && raw_q.size() != 0) void'(raw_q.pop_front());
            hold_prev = out_valid && !out_ready;
            prev_b    = {out_data, out_sop, out_eop, out_empty};
        end
    end

    initial begin
        int s;
        int e0;
        rst_n      = 1'b0;
        desc_valid = 1'b0;
        desc_len   = '0;
        raw_valid  = 1'b0;
        raw_data   = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_out_sop", 96'(out_sop), 96'(0));
        chk("rst_out_eop", 96'(out_eop), 96'(0));
        chk("rst_out_empty", 96'(out_empty), 96'(0));
        chk("rst_out_data", 96'(out_data), 96'(0));
        chk("rst_desc_err", 96'(desc_err), 96'(0));
        chk("rst_desc_ready", 96'(desc_ready), 96'(0));
        chk("rst_raw_ready", 96'(raw_ready), 96'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_desc_ready", 96'(desc_ready), 96'(1));
        chk("idle_raw_ready", 96'(raw_ready), 96'(0));
        mon_en = 1;
        drv_en = 1;

        s = seen.size();
        add_pkt(16, 64'hA0, 0);
        drain("len16", 200);
        chk_seen("len16_b0", s, 64'hA0, 1, 0, 0);
        chk_seen("len16_b1", s + 1, 64'hA1, 0, 1, 0);

        s = seen.size();
        add_pkt(13, 64'hB0, 0);
        drain("len13", 200);
        chk("len13_beats", 96'(seen.size() - s), 96'(2));
        chk_seen("len13_b1", s + 1, 64'hB1, 0, 1, 3);

        s = seen.size();
        add_pkt(1, 64'hC0, 0);
        drain("len1", 200);
        chk_seen("len1_b0", s, 64'hC0, 1, 1, 7);

        s = seen.size();
        e0 = err_seen;
        add_pkt(0, 64'h0, 0);
        drain("len0", 200);
        repeat (3) @(negedge clk);
        chk("len0_no_beats", 96'(seen.size() - s), 96'(0));
        chk("len0_err_pulses", 96'(err_seen - e0), 96'(1));
`ifdef PKT_TX_FRAMER_STATS_EN
        chk("stat_err_cnt", 96'(stat_err_cnt), 96'(1));
        chk("stat_pkt_cnt", 96'(stat_pkt_cnt), 96'(3));
`endif

        s = seen.size();
        add_pkt(32, 64'h100, 0);
        wait_seen("hold_wait", s + 2, 200);
        rdy_low = 5;
        drain("hold", 300);
        for (int i = 0; i < 4; i++) chk_seen("hold_order", s + i, 64'h100 + 64'(i), i == 0, i == 3, 0);

        s = seen.size();
        add_pkt(40, 64'h200, 0);
        wait_seen("rst_wait", s + 2, 200);
        @(posedge clk);
        #1;
        mon_en     = 0;
        drv_en     = 0;
        rst_n      = 1'b0;
        desc_valid = 1'b0;
        raw_valid  = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_valid", 96'(out_valid), 96'(0));
        chk("rst_mid_desc_ready", 96'(desc_ready), 96'(0));
        desc_q.delete();
        raw_q.delete();
        exp_q.delete();
        err_pend  = 0;
        hold_prev = 0;
        rawf_prev = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1;
        drv_en = 1;

        s = seen.size();
        add_pkt(8, 64'h300, 0);
        drain("after_rst", 200);
        chk_seen("after_rst_b0", s, 64'h300, 1, 1, 0);
`ifdef PKT_TX_FRAMER_STATS_EN
        chk("stat_pkt_after_rst", 96'(stat_pkt_cnt), 96'(1));
        chk("stat_err_after_rst", 96'(stat_err_cnt), 96'(0));
`endif

        s = seen.size();
        add_pkt(8, 64'h400, 0);
        add_pkt(8, 64'h500, 0);
        drain("b2b", 200);
        chk_seen("b2b_p0", s, 64'h400, 1, 1, 0);
        chk_seen("b2b_p1", s + 1, 64'h500, 1, 1, 0);
        if (seen_cyc.size() >= s + 2)
            chk("b2b_gap", 96'(seen_cyc[s + 1] - seen_cyc[s]), 96'(2));

        raw_pct = 70;
        rdy_pct = 60;
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(9))
                0:       add_pkt(0, '0, 1);
                1:       add_pkt(1, '0, 1);
                2:       add_pkt(8 * $urandom_range(1, 6), '0, 1);
                default: add_pkt($urandom_range(1, 60), '0, 1);
            endcase
        end
        drain("random", 20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
